// File: rtl/vivepass_lane_arbiter_if.sv
// Lane-side and validator-side signals of the vivepass lane arbiter.
// master = arbiter, slave = lanes/validator environment.
interface vivepass_lane_arbiter_if #(
    parameter int N_LANES = 4
);
    logic [N_LANES-1:0]   req;
    logic [2*N_LANES-1:0] lvl;
    logic                 val_start;
    logic [1:0]           val_lvl;
    logic                 val_done;
    logic                 val_ok;
    logic [N_LANES-1:0]   gnt;
    logic [N_LANES-1:0]   gate_open;
    logic                 deny_pulse;
    logic                 timeout_flag;
    logic                 busy;

    modport master (
        input  req, lvl, val_done, val_ok,
        output val_start, val_lvl, gnt, gate_open, deny_pulse, timeout_flag, busy
    );

    modport slave (
        output req, lvl, val_done, val_ok,
        input  val_start, val_lvl, gnt, gate_open, deny_pulse, timeout_flag, busy
    );
endinterface

// File: rtl/vivepass_lane_arbiter.sv
// Round-robin arbiter sharing one pass-validation unit among N_LANES lanes.
// Optional statistics counters are enabled with macro VIVEPASS_STATS_EN.
//
// state | meaning
// IDLE  | waiting for any lane request, round-robin pick from rr_ptr
// ISSUE | one-cycle val_start pulse for the granted lane
// WAIT  | waiting for val_done, down-counter bounds the wait
// OPEN  | gate_open held for OPEN_CYCLES cycles
// DENY  | one-cycle deny_pulse (timeout_flag too when timed out)
module vivepass_lane_arbiter #(
    parameter int N_LANES        = 4,
    parameter int OPEN_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    vivepass_lane_arbiter_if.master bus
`ifdef VIVEPASS_STATS_EN
    ,
    output logic [15:0] served_cnt,
    output logic [15:0] denied_cnt,
    output logic [15:0] timeout_cnt
`endif
);
    localparam int PW   = $clog2(N_LANES);
    localparam int TMAX = (OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    // WAIT lasts TIMEOUT_CYCLES-1 cycles, so deny lands TIMEOUT_CYCLES after val_start
    localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OPEN,
        S_DENY
    } state_t;

    state_t             state_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [PW-1:0]      lane_q;
    logic [TW-1:0]      tmr_q;
    logic [N_LANES-1:0] gnt_q;
    logic [N_LANES-1:0] gate_q;
    logic               val_start_q;
    logic [1:0]         val_lvl_q;
    logic               deny_q;
    logic               tmo_q;
    logic               busy_q;

    logic [N_LANES-1:0] rot_d;
    logic               any_req_d;
    logic [PW-1:0]      off_d;
    logic [PW:0]        sum_d;
    logic [PW-1:0]      sel_d;
    logic [1:0]         lvl_sel_d;
    logic [PW-1:0]      next_ptr_d;
    logic               open_enter;
    logic               reject_hit;
    logic               timeout_hit;
    logic               deny_enter;

    // Rotate requests so bit 0 is the lane at rr_ptr; lowest set bit wins.
    always_comb begin
        rot_d     = N_LANES'({bus.req, bus.req} >> rr_ptr_q);
        any_req_d = 1'b0;
        off_d     = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (rot_d[i]) begin
                any_req_d = 1'b1;
                off_d     = PW'(i);
            end
        end
        sum_d = {1'b0, rr_ptr_q} + {1'b0, off_d};
        if (sum_d >= (PW+1)'(N_LANES)) begin
            sum_d = sum_d - (PW+1)'(N_LANES);
        end
        sel_d     = sum_d[PW-1:0];
        lvl_sel_d = '0;
        for (int j = 0; j < N_LANES; j++) begin
            if (sel_d == PW'(j)) begin
                lvl_sel_d = bus.lvl[2*j +: 2];
            end
        end
    end

    always_comb begin
        next_ptr_d  = (lane_q == PW'(N_LANES - 1)) ? '0 : lane_q + PW'(1);
        open_enter  = (state_q == S_WAIT) && bus.val_done && bus.val_ok;
        reject_hit  = (state_q == S_WAIT) && bus.val_done && !bus.val_ok;
        timeout_hit = (state_q == S_WAIT) && !bus.val_done && (tmr_q == '0);
        deny_enter  = reject_hit || timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            lane_q      <= '0;
            tmr_q       <= '0;
            gnt_q       <= '0;
            gate_q      <= '0;
            val_start_q <= 1'b0;
            val_lvl_q   <= '0;
            deny_q      <= 1'b0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            val_start_q <= 1'b0;
            deny_q      <= 1'b0;
            tmo_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        state_q     <= S_ISSUE;
                        lane_q      <= sel_d;
                        gnt_q       <= N_LANES'(1) << sel_d;
                        val_lvl_q   <= lvl_sel_d;
                        val_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        tmr_q       <= '0;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    tmr_q   <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (open_enter) begin
                        state_q <= S_OPEN;
                        gate_q  <= gnt_q;
                        tmr_q   <= OPEN_LOAD;
                    end else if (deny_enter) begin
                        state_q <= S_DENY;
                        deny_q  <= 1'b1;
                        tmo_q   <= timeout_hit;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                S_OPEN: begin
                    if (tmr_q == '0) begin
                        state_q  <= S_IDLE;
                        gate_q   <= '0;
                        gnt_q    <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= next_ptr_d;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                S_DENY: begin
                    state_q  <= S_IDLE;
                    gnt_q    <= '0;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= next_ptr_d;
                end
                default: begin
                    state_q <= S_IDLE;
                    gate_q  <= '0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.val_start    = val_start_q;
    assign bus.val_lvl      = val_lvl_q;
    assign bus.gnt          = gnt_q;
    assign bus.gate_open    = gate_q;
    assign bus.deny_pulse   = deny_q;
    assign bus.timeout_flag = tmo_q;
    assign bus.busy         = busy_q;

`ifdef VIVEPASS_STATS_EN
    logic [15:0] served_q;
    logic [15:0] denied_q;
    logic [15:0] timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            served_q  <= '0;
            denied_q  <= '0;
            timeout_q <= '0;
        end else begin
            if (open_enter && (served_q != 16'hFFFF)) begin
                served_q <= served_q + 16'd1;
            end
            if (deny_enter && (denied_q != 16'hFFFF)) begin
                denied_q <= denied_q + 16'd1;
            end
            if (timeout_hit && (timeout_q != 16'hFFFF)) begin
                timeout_q <= timeout_q + 16'd1;
            end
        end
    end

    assign served_cnt  = served_q;
    assign denied_cnt  = denied_q;
    assign timeout_cnt = timeout_q;
`endif
endmodule

// File: tb/tb_vivepass_lane_arbiter.sv
// Self-checking bench for vivepass_lane_arbiter: vector table plus scoreboard
// of expected grants/outcomes; stats checks when VIVEPASS_STATS_EN is defined.
module tb_vivepass_lane_arbiter;
    localparam int NL = 4;
    localparam int OC = 8;
    localparam int TO = 16;

    localparam int M_OK    = 0;
    localparam int M_REJ   = 1;
    localparam int M_NONE  = 2;
    localparam int M_EARLY = 3;

    localparam int O_OPEN = 0;
    localparam int O_DENY = 1;
    localparam int O_TMO  = 2;

    typedef struct {
        logic [3:0] req;
        logic [7:0] lvl;
        int         mode;
        int         dly;
        bit         hold;
        logic [3:0] exp_gnt;
        logic [1:0] exp_lvl;
        int         exp_out;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] lvl;
        int         outcome;
    } exp_t;

    logic clk;
    logic reset;
    vivepass_lane_arbiter_if #(.N_LANES(NL)) bus ();

`ifdef VIVEPASS_STATS_EN
    logic [15:0] served_cnt;
    logic [15:0] denied_cnt;
    logic [15:0] timeout_cnt;
`endif

    vivepass_lane_arbiter #(
        .N_LANES(NL),
        .OPEN_CYCLES(OC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef VIVEPASS_STATS_EN
        ,
        .served_cnt(served_cnt),
        .denied_cnt(denied_cnt),
        .timeout_cnt(timeout_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    int   e_served = 0;
    int   e_denied = 0;
    int   e_tmo = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   mon_out;
    logic [3:0] prev_gate = '0;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event did not occur within its bound (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor: checks grant/level at val_start, outcome at gate rise or deny.
    always @(negedge clk) begin
        if (!reset) begin
            chk("gnt_onehot", 32'($onehot0(bus.gnt)), 1);
            chk("gate_onehot", 32'($onehot0(bus.gate_open)), 1);
            chk("gate_in_gnt", 32'(bus.gate_open & ~bus.gnt), 0);
            if (bus.val_start) begin
                if (sb_q.size() == 0) begin
                    fail_bound("unexpected_val_start");
                end else begin
                    chk("grant_lane", 32'(bus.gnt), 32'(sb_q[0].gnt));
                    chk("grant_lvl", 32'(bus.val_lvl), 32'(sb_q[0].lvl));
                end
            end
            if ((bus.gate_open != 0 && prev_gate == 0) || bus.deny_pulse) begin
                if (sb_q.size() == 0) begin
                    fail_bound("unexpected_outcome");
                end else begin
                    mon_e   = sb_q.pop_front();
                    mon_out = bus.deny_pulse ? (bus.timeout_flag ? O_TMO : O_DENY) : O_OPEN;
                    chk("outcome", 32'(mon_out), 32'(mon_e.outcome));
                    chk("outcome_lvl", 32'(bus.val_lvl), 32'(mon_e.lvl));
                    if (!bus.deny_pulse) chk("gate_lane", 32'(bus.gate_open), 32'(mon_e.gnt));
                    else chk("deny_gate_closed", 32'(bus.gate_open), 0);
                end
            end else begin
                chk("tmo_alone", 32'(bus.timeout_flag), 0);
            end
        end
        prev_gate <= bus.gate_open;
    end

    task automatic run_txn(input vec_t v, output int issue_wait);
        bit seen;
        bit done;
        int lat;
        int open_n;
        bus.req = v.req;
        bus.lvl = v.lvl;
        sb_q.push_back('{gnt: v.exp_gnt, lvl: v.exp_lvl, outcome: v.exp_out});
        if (v.exp_out == O_OPEN) e_served++;
        else e_denied++;
        if (v.exp_out == O_TMO) e_tmo++;
        issue_wait = 0;
        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.val_start) begin
                seen = 1;
                issue_wait = k;
            end
        end
        if (!seen) begin
            fail_bound("issue");
            sb_q.delete();
            bus.req = '0;
            return;
        end
        if (v.mode == M_EARLY) begin
            bus.val_done = 1'b1;
            bus.val_ok   = 1'b1;
        end
        if (!v.hold) begin
            bus.req = '0;
            bus.lvl = ~v.lvl;
        end
        lat  = 0;
        done = 0;
        for (int k = 1; k <= TO + 10 && !done; k++) begin
            @(negedge clk);
            if (k == 1) chk("start_single", 32'(bus.val_start), 0);
            bus.val_done = ((v.mode == M_OK || v.mode == M_REJ) && k == v.dly + 1);
            bus.val_ok   = (v.mode == M_OK);
            if (bus.gate_open != 0 || bus.deny_pulse) begin
                done = 1;
                lat  = k;
            end
        end
        bus.val_done = 1'b0;
        if (!done) begin
            fail_bound("outcome");
            sb_q.delete();
            bus.req = '0;
            return;
        end
        chk("latency", 32'(lat), 32'((v.exp_out == O_TMO) ? TO : v.dly + 2));
        open_n = (bus.gate_open != 0) ? 1 : 0;
        done = 0;
        for (int k = 1; k <= OC + 5 && !done; k++) begin
            @(negedge clk);
            if (!bus.busy) done = 1;
            else if (bus.gate_open != 0) open_n++;
        end
        chk("busy_release", 32'(done), 1);
        chk("open_len", 32'(open_n), 32'((v.exp_out == O_OPEN) ? OC : 0));
        bus.req = '0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   iw;
        bit   seen;
        vec_t va;

        vecs[0]  = '{4'b0010, 8'h0C, M_OK,    0,  1'b1, 4'b0010, 2'b11, O_OPEN};
        vecs[1]  = '{4'b1000, 8'h40, M_NONE,  0,  1'b1, 4'b1000, 2'b01, O_TMO};
        vecs[2]  = '{4'b1111, 8'hE4, M_OK,    0,  1'b1, 4'b0001, 2'b00, O_OPEN};
        vecs[3]  = '{4'b1111, 8'hE4, M_OK,    3,  1'b1, 4'b0010, 2'b01, O_OPEN};
        vecs[4]  = '{4'b1111, 8'hE4, M_OK,    1,  1'b1, 4'b0100, 2'b10, O_OPEN};
        vecs[5]  = '{4'b1111, 8'hE4, M_OK,    14, 1'b1, 4'b1000, 2'b11, O_OPEN};
        vecs[6]  = '{4'b1111, 8'hE4, M_OK,    0,  1'b1, 4'b0001, 2'b00, O_OPEN};
        vecs[7]  = '{4'b1011, 8'h1B, M_REJ,   0,  1'b1, 4'b0010, 2'b10, O_DENY};
        vecs[8]  = '{4'b1011, 8'h1B, M_REJ,   14, 1'b1, 4'b1000, 2'b00, O_DENY};
        vecs[9]  = '{4'b0110, 8'h1B, M_EARLY, 0,  1'b1, 4'b0010, 2'b10, O_TMO};
        vecs[10] = '{4'b0001, 8'h1B, M_OK,    2,  1'b0, 4'b0001, 2'b11, O_OPEN};
        vecs[11] = '{4'b1001, 8'h1B, M_OK,    0,  1'b1, 4'b1000, 2'b00, O_OPEN};
        vecs[12] = '{4'b0001, 8'h1B, M_OK,    0,  1'b1, 4'b0001, 2'b11, O_OPEN};

        reset        = 1'b1;
        bus.req      = 4'b0100;
        bus.lvl      = 8'h20;
        bus.val_done = 1'b0;
        bus.val_ok   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_gate", 32'(bus.gate_open), 0);
        chk("rst_val_start", 32'(bus.val_start), 0);
        chk("rst_deny", 32'(bus.deny_pulse), 0);
        chk("rst_tmo", 32'(bus.timeout_flag), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_val_lvl", 32'(bus.val_lvl), 0);

        reset = 1'b0;
        va = '{4'b0100, 8'h20, M_OK, 0, 1'b1, 4'b0100, 2'b10, O_OPEN};
        run_txn(va, iw);
        chk("first_grant_delay", 32'(iw), 1);

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i], iw);
            chk("issue_wait", 32'(iw), 1);
        end

        // val_done while idle must be ignored
        bus.val_done = 1'b1;
        bus.val_ok   = 1'b1;
        repeat (2) @(negedge clk);
        bus.val_done = 1'b0;
        @(negedge clk);
        chk("idle_done_busy", 32'(bus.busy), 0);
        chk("idle_done_gate", 32'(bus.gate_open), 0);

`ifdef VIVEPASS_STATS_EN
        chk("served_cnt", 32'(served_cnt), 32'(e_served));
        chk("denied_cnt", 32'(denied_cnt), 32'(e_denied));
        chk("timeout_cnt", 32'(timeout_cnt), 32'(e_tmo));
`endif

        // reset asserted while the gate is open
        bus.req = 4'b0100;
        bus.lvl = 8'h10;
        sb_q.push_back('{gnt: 4'b0100, lvl: 2'b01, outcome: O_OPEN});
        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.val_start) seen = 1;
        end
        if (!seen) fail_bound("rst_issue");
        @(negedge clk);
        bus.val_done = 1'b1;
        bus.val_ok   = 1'b1;
        @(negedge clk);
        bus.val_done = 1'b0;
        chk("rst_pre_gate", 32'(bus.gate_open), 32'(4'b0100));
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        @(negedge clk);
        chk("midrst_gate", 32'(bus.gate_open), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_gnt", 32'(bus.gnt), 0);
        e_served = 0;
        e_denied = 0;
        e_tmo    = 0;
`ifdef VIVEPASS_STATS_EN
        chk("rst_served_cnt", 32'(served_cnt), 0);
        chk("rst_denied_cnt", 32'(denied_cnt), 0);
        chk("rst_timeout_cnt", 32'(timeout_cnt), 0);
`endif
        sb_q.delete();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(bus.busy), 0);

        // rr_ptr was 1 before reset; after reset lane 0 must win over lane 1
        va = '{4'b0011, 8'h0E, M_OK, 0, 1'b1, 4'b0001, 2'b10, O_OPEN};
        run_txn(va, iw);
        chk("post_rst_issue_wait", 32'(iw), 1);
`ifdef VIVEPASS_STATS_EN
        chk("final_served_cnt", 32'(served_cnt), 32'(e_served));
        chk("final_denied_cnt", 32'(denied_cnt), 32'(e_denied));
`endif
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vivepass_lane_arbiter.md
Name: vivepass_lane_arbiter

Overview:
- Shares one pass-validation unit (Moore/Mealy validator pair) among N_LANES entry lanes.
- Round-robin arbitration; sequences each transaction as grant -> start validation -> wait for result -> open gate or deny.
- Sits between the lane sensors/readers and the validation unit; drives per-lane gate-open outputs.

Parameters:
- N_LANES, 4, number of requesting lanes (2..8)
- OPEN_CYCLES, 8, cycles gate_open stays high on acceptance (>=1)
- TIMEOUT_CYCLES, 16, max cycles waiting for val_done before forced deny (>=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_LANES  per-lane access request, level, held by lane until served
- lvl  in  2*N_LANES  per-lane 2-bit pass level; lane k at [2k+1:2k]
- val_start  out  1  one-cycle start pulse to validation unit
- val_lvl  out  2  pass level of granted lane, stable from val_start until transaction end
- val_done  in  1  validation complete, one-cycle pulse
- val_ok  in  1  validation result, sampled only when val_done=1
- gnt  out  N_LANES  one-hot grant of lane being served, else 0
- gate_open  out  N_LANES  one-hot gate drive for accepted lane
- deny_pulse  out  1  one-cycle pulse on rejection or timeout
- timeout_flag  out  1  one-cycle pulse, coincident with deny_pulse, on timeout only
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0. gnt, gate_open, val_start, deny_pulse, timeout_flag, busy = 0. val_lvl=0. Timers=0. Reset mid-transaction aborts immediately and drives the same values; the gate closes on the next edge.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, OPEN, DENY.
- IDLE: if any req bit is set, select first set lane searching rr_ptr, rr_ptr+1, ... mod N_LANES. Latch k and lvl[k]. Next state ISSUE; gnt[k]=1 from this edge. No req: stay.
- ISSUE: val_start=1 for exactly this one cycle; val_lvl=latched level. -> WAIT; timer cleared.
- WAIT: timer increments each cycle.
  - val_done=1 & val_ok=1 -> OPEN.
  - val_done=1 & val_ok=0 -> DENY.
  - timer reaches TIMEOUT_CYCLES-1 with no val_done -> DENY with timeout flag set.
  - val_done on the same cycle as the timeout limit: val_done wins.
- OPEN: gate_open[k]=1 for exactly OPEN_CYCLES cycles, then -> IDLE.
- DENY: deny_pulse=1 for one cycle (timeout_flag=1 also if entered by timeout), then -> IDLE.
- On leaving OPEN or DENY:
  - rr_ptr = (k+1) mod N_LANES.
  - gnt cleared.
  - val_lvl holds its last value.
- Minimum gap between transactions: one IDLE cycle.
- Lane dropping req after grant: ignored; the transaction completes normally.
- val_done outside WAIT: ignored.
- lvl changes after latch: ignored.
- gnt and gate_open are never multi-hot. gate_open is never high outside OPEN.
- Latency with val_done in the first WAIT cycle: req seen in IDLE at cycle 0 -> gnt cycle 1 -> val_start cycle 1 (ISSUE) -> gate_open from cycle 3.

Optional Feature:
- Macro VIVEPASS_STATS_EN.
- Defined: adds outputs served_cnt[15:0], denied_cnt[15:0], timeout_cnt[15:0].
  - Each increments once per OPEN entry, DENY entry, or timeout respectively.
  - Counters saturate at 16'hFFFF and clear on reset.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with req=4'b0100, then release reset -> gnt=4'b0100 one cycle after; val_start single pulse; val_lvl=lvl[5:4].
- Lane 1 requests, validator returns val_done=1/val_ok=1 in the first WAIT cycle -> gate_open=4'b0010 for exactly 8 cycles, then busy=0; no deny_pulse.
- req=4'b1111 held, validator always OK -> grants in order lane 0,1,2,3,0. No lane is served twice before the others.
- Lane 3 requests, validator never responds -> deny_pulse=1 and timeout_flag=1 on the same cycle, 16 cycles after val_start. gate_open stays 0; next grant goes to lane 0 first.
- val_ok=0 with val_done -> one-cycle deny_pulse, timeout_flag=0. Also: reset asserted during OPEN -> gate_open=0 and state=IDLE on the next edge.
- (VIVEPASS_STATS_EN) 3 accepts, 1 reject, 1 timeout -> served_cnt=3, denied_cnt=2, timeout_cnt=1.
